// File: rtl/quad_speed_counter.sv
// quad_speed_counter: 4x quadrature decoder for one odometer wheel.
// Accumulates the signed edge count over a fixed window of WINDOW_CYCLES clocks and
// publishes it as a saturating 16-bit two's-complement speed word with a valid pulse.
module quad_speed_counter #(
    parameter int unsigned WINDOW_CYCLES = 50000,
    parameter bit          INVERT_DIR    = 1'b0
) (
    input  logic        theClock,
    input  logic        theReset_n,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        clear,
    output logic [15:0] speed,
    output logic        speed_valid,
    output logic        sat,
    output logic        err
);

    localparam int unsigned WcntW = $clog2(WINDOW_CYCLES);
    localparam logic [WcntW-1:0] WcntLast = WcntW'(WINDOW_CYCLES - 1);

    // Two-bit step codes: +1, -1 and none.
    localparam logic [1:0] StepNone = 2'b00;
    localparam logic [1:0] StepFwd  = 2'b01;
    localparam logic [1:0] StepRev  = 2'b11;

    // Synchronisers and decode history
    logic       a_meta_q, a_sync_q;
    logic       b_meta_q, b_sync_q;
    logic [1:0] ab_prev_q;
    logic [1:0] ab_cur;

    // Decode results
    logic [1:0] phase_diff;
    logic [1:0] step_raw;
    logic [1:0] step;
    logic       illegal;

    // Accumulation datapath
    logic [16:0] sum;
    logic        clamp;
    logic [15:0] acc_sum;
    logic        terminal;

    // Window state
    logic [15:0]      acc_q, acc_d;
    logic             sat_w_q, sat_w_d;
    logic [WcntW-1:0] wcnt_q, wcnt_d;
    logic [15:0]      speed_q, speed_d;
    logic             valid_q, valid_d;
    logic             sat_q, sat_d;
    logic             err_q, err_d;

    // Position of a Gray-coded {A,B} pair along the forward sequence 00,10,11,01.
    function automatic logic [1:0] phase_of(input logic [1:0] ab);
        logic [1:0] ph;
        case (ab)
            2'b00:   ph = 2'd0;
            2'b10:   ph = 2'd1;
            2'b11:   ph = 2'd2;
            default: ph = 2'd3;
        endcase
        return ph;
    endfunction

    // Double-flop each pin into theClock; keep the previous synced pair as decode history.
    always_ff @(posedge theClock or negedge theReset_n) begin
        if (!theReset_n) begin
            a_meta_q  <= 1'b0;
            a_sync_q  <= 1'b0;
            b_meta_q  <= 1'b0;
            b_sync_q  <= 1'b0;
            ab_prev_q <= 2'b00;
        end else begin
            a_meta_q  <= enc_a;
            a_sync_q  <= a_meta_q;
            b_meta_q  <= enc_b;
            b_sync_q  <= b_meta_q;
            // History keeps tracking during clear so its release cannot fake a step.
            ab_prev_q <= ab_cur;
        end
    end

    assign ab_cur = {a_sync_q, b_sync_q};

    // Decode prev->cur into a +1/-1/0 step; a jump of two phases is illegal.
    always_comb begin
        step_raw   = StepNone;
        illegal    = 1'b0;
        phase_diff = phase_of(ab_cur) - phase_of(ab_prev_q);
        case (phase_diff)
            2'd1:    step_raw = StepFwd;
            2'd3:    step_raw = StepRev;
            2'd2:    illegal  = 1'b1;
            default: step_raw = StepNone;
        endcase
        step = INVERT_DIR ? (2'd0 - step_raw) : step_raw;
    end

    // Saturating add of the step into the accumulator; overflow shows as sum[16] != sum[15].
    always_comb begin
        sum      = {acc_q[15], acc_q} + {{15{step[1]}}, step};
        clamp    = sum[16] ^ sum[15];
        acc_sum  = sum[15:0];
        if (clamp) begin
            acc_sum = sum[16] ? 16'h8000 : 16'h7FFF;
        end
        terminal = (wcnt_q == WcntLast);
    end

    // Window sequencing: accumulate, close the window on the terminal cycle, clear wins.
    always_comb begin
        acc_d   = acc_q;
        sat_w_d = sat_w_q;
        wcnt_d  = wcnt_q;
        speed_d = speed_q;
        valid_d = 1'b0;
        sat_d   = sat_q;
        err_d   = err_q | illegal;

        if (clear) begin
            acc_d   = '0;
            sat_w_d = 1'b0;
            wcnt_d  = '0;
            speed_d = '0;
            sat_d   = 1'b0;
            err_d   = 1'b0;
        end else if (terminal) begin
            // The terminal-cycle step belongs to the window being closed.
            speed_d = acc_sum;
            sat_d   = sat_w_q | clamp;
            valid_d = 1'b1;
            acc_d   = '0;
            sat_w_d = 1'b0;
            wcnt_d  = '0;
        end else begin
            acc_d   = acc_sum;
            sat_w_d = sat_w_q | clamp;
            wcnt_d  = wcnt_q + 1'b1;
        end
    end

    // Window and output state register.
    always_ff @(posedge theClock or negedge theReset_n) begin
        if (!theReset_n) begin
            acc_q   <= '0;
            sat_w_q <= 1'b0;
            wcnt_q  <= '0;
            speed_q <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            sat_w_q <= sat_w_d;
            wcnt_q  <= wcnt_d;
            speed_q <= speed_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
        end
    end

    assign speed       = speed_q;
    assign speed_valid = valid_q;
    assign sat         = sat_q;
    assign err         = err_q;

endmodule

// File: tb/tb_quad_speed_counter.sv
// Testbench for quad_speed_counter: a forward and an inverted instance share the pins,
// a third long-window instance covers saturation. Window results go through a scoreboard.
`timescale 1ns/100ps
module tb_quad_speed_counter;

    localparam int unsigned WIN     = 100;
    localparam int unsigned WIN_SAT = 32800;

    logic        clk;
    logic        rst_n;
    logic        enc_a, enc_b, clear;
    logic        sat_a, sat_b, sat_clear;
    logic [15:0] speed_f, speed_i, speed_s;
    logic        valid_f, valid_i, valid_s;
    logic        sat_f, sat_i, sat_s;
    logic        err_f, err_i, err_s;

    int total = 0;
    int bad   = 0;
    int pos   = 0;
    int pos_s = 0;
    int nv_f  = 0;

    logic [16:0] exp_f[$], exp_i[$], exp_s[$];
    logic [16:0] obs_f[$], obs_i[$], obs_s[$];

    quad_speed_counter #(.WINDOW_CYCLES(WIN), .INVERT_DIR(1'b0)) u_fwd (
        .theClock(clk), .theReset_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
        .speed(speed_f), .speed_valid(valid_f), .sat(sat_f), .err(err_f)
    );

    quad_speed_counter #(.WINDOW_CYCLES(WIN), .INVERT_DIR(1'b1)) u_inv (
        .theClock(clk), .theReset_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
        .speed(speed_i), .speed_valid(valid_i), .sat(sat_i), .err(err_i)
    );

    quad_speed_counter #(.WINDOW_CYCLES(WIN_SAT), .INVERT_DIR(1'b0)) u_sat (
        .theClock(clk), .theReset_n(rst_n), .enc_a(sat_a), .enc_b(sat_b), .clear(sat_clear),
        .speed(speed_s), .speed_valid(valid_s), .sat(sat_s), .err(err_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Capture every published window 1 ns after the edge that produced it.
    always begin
        @(posedge clk);
        #1;
        if (valid_f === 1'b1) begin
            obs_f.push_back({sat_f, speed_f});
            nv_f++;
        end
        if (valid_i === 1'b1) obs_i.push_back({sat_i, speed_i});
        if (valid_s === 1'b1) obs_s.push_back({sat_s, speed_s});
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    function automatic logic [1:0] gray(input int p);
        logic [1:0] g;
        case (p % 4)
            0:       g = 2'b00;
            1:       g = 2'b10;
            2:       g = 2'b11;
            default: g = 2'b01;
        endcase
        return g;
    endfunction

    task automatic move(input int delta);
        pos = (pos + delta + 4) % 4;
        {enc_a, enc_b} = gray(pos);
    endtask

    task automatic move_sat(input int delta);
        pos_s = (pos_s + delta + 4) % 4;
        {sat_a, sat_b} = gray(pos_s);
    endtask

    function automatic int obs_count(input int which);
        if (which == 0) return obs_f.size();
        if (which == 1) return obs_i.size();
        return obs_s.size();
    endfunction

    task automatic wait_obs(input int which, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k <= budget; k++) begin
            if (obs_count(which) > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic flush_small();
        obs_f.delete(); obs_i.delete(); exp_f.delete(); exp_i.delete();
    endtask

    // Return on the negedge right after a window closes, with the scoreboard empty.
    task automatic align_small();
        int  start;
        bit  seen;
        start = nv_f;
        seen  = 1'b0;
        for (int k = 0; k < 2 * WIN + 10; k++) begin
            @(negedge clk);
            if (nv_f != start) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL align: no speed_valid within %0d cycles, want one", 2 * WIN + 10);
        end
        flush_small();
    endtask

    task automatic check_window(input string name);
        bit          ok;
        logic [16:0] got, want;
        wait_obs(0, 2 * WIN + 10, ok);
        total++;
        if (!ok || obs_f.size() != 1 || obs_i.size() != 1) begin
            bad++;
            $display("FAIL %s_pulse: pulses fwd=%0d inv=%0d, want 1 each", name,
                     obs_f.size(), obs_i.size());
            flush_small();
        end else begin
            got  = obs_f.pop_front();
            want = exp_f.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s_fwd: {sat,speed}=%h, want %h", name, got, want);
            end
            got  = obs_i.pop_front();
            want = exp_i.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s_inv: {sat,speed}=%h, want %h", name, got, want);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; sat_clear = 1'b0;
        enc_a = 1'b0; enc_b = 1'b0; sat_a = 1'b0; sat_b = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({speed_f, valid_f, sat_f, err_f} !== 19'd0) begin
            bad++;
            $display("FAIL reset_fwd: outputs=%h, want 0", {speed_f, valid_f, sat_f, err_f});
        end
        total++;
        if ({speed_i, valid_i, sat_i, err_i} !== 19'd0) begin
            bad++;
            $display("FAIL reset_inv: outputs=%h, want 0", {speed_i, valid_i, sat_i, err_i});
        end
        total++;
        if ({speed_s, valid_s, sat_s, err_s} !== 19'd0) begin
            bad++;
            $display("FAIL reset_sat: outputs=%h, want 0", {speed_s, valid_s, sat_s, err_s});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        bit          ok;
        logic [16:0] got, want;
        // Restart the long window at a known cycle.
        @(negedge clk);
        sat_clear = 1'b1;
        @(negedge clk);
        sat_clear = 1'b0;
        obs_s.delete(); exp_s.delete();
        exp_s.push_back({1'b1, 16'h7FFF});
        for (int i = 0; i < 32770; i++) begin
            move_sat(1);
            @(negedge clk);
        end
        for (int w = 0; w < 2; w++) begin
            if (w == 1) begin
                exp_s.push_back({1'b0, 16'd3});
                for (int i = 0; i < 3; i++) begin
                    move_sat(1);
                    repeat (4) @(negedge clk);
                end
            end
            wait_obs(2, WIN_SAT + 10, ok);
            total++;
            if (!ok || obs_s.size() != 1) begin
                bad++;
                $display("FAIL sat_pulse%0d: pulses=%0d, want 1", w, obs_s.size());
                obs_s.delete(); exp_s.delete();
            end else begin
                got  = obs_s.pop_front();
                want = exp_s.pop_front();
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL sat_window%0d: {sat,speed}=%h, want %h", w, got, want);
                end
            end
        end
        total++;
        if (err_s !== 1'b0) begin
            bad++;
            $display("FAIL sat_err: err=%b, want 0", err_s);
        end
    endtask

    task automatic test_forward();
        align_small();
        exp_f.push_back({1'b0, 16'd25});
        exp_i.push_back({1'b0, 16'hFFE7});
        for (int i = 0; i < 25; i++) begin
            move(1);
            repeat (4) @(negedge clk);
        end
        check_window("fwd25");
        @(negedge clk);
        total++;
        if (valid_f !== 1'b0 || err_f !== 1'b0) begin
            bad++;
            $display("FAIL fwd25_after: valid=%b err=%b, want 0 0", valid_f, err_f);
        end
    endtask

    task automatic test_reverse_invert();
        align_small();
        exp_f.push_back({1'b0, 16'hFFF6});
        exp_i.push_back({1'b0, 16'h000A});
        for (int i = 0; i < 10; i++) begin
            move(-1);
            repeat (4) @(negedge clk);
        end
        check_window("rev10");
    endtask

    task automatic test_window_boundary();
        align_small();
        // Pin change here reaches the accumulator exactly on the terminal cycle.
        repeat (WIN - 3) @(negedge clk);
        move(1);
        exp_f.push_back({1'b0, 16'd1});
        exp_i.push_back({1'b0, 16'hFFFF});
        check_window("edge_term");
        exp_f.push_back({1'b0, 16'd0});
        exp_i.push_back({1'b0, 16'd0});
        check_window("edge_next");
    endtask

    task automatic test_illegal();
        align_small();
        move(2);
        exp_f.push_back({1'b0, 16'd0});
        exp_i.push_back({1'b0, 16'd0});
        check_window("illegal");
        total++;
        if (err_f !== 1'b1 || err_i !== 1'b1) begin
            bad++;
            $display("FAIL illegal_err: err fwd=%b inv=%b, want 1 1", err_f, err_i);
        end
        exp_f.push_back({1'b0, 16'd0});
        exp_i.push_back({1'b0, 16'd0});
        check_window("illegal_next");
        total++;
        if (err_f !== 1'b1) begin
            bad++;
            $display("FAIL illegal_sticky: err=%b, want 1", err_f);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        total++;
        if (err_f !== 1'b0 || err_i !== 1'b0) begin
            bad++;
            $display("FAIL illegal_clear: err fwd=%b inv=%b, want 0 0", err_f, err_i);
        end
    endtask

    // Window of 7 steps, then 7 more steps and an illegal jump in the next window.
    task automatic dirty_window();
        align_small();
        exp_f.push_back({1'b0, 16'd7});
        exp_i.push_back({1'b0, 16'hFFF9});
        for (int i = 0; i < 7; i++) begin
            move(1);
            repeat (4) @(negedge clk);
        end
        check_window("pre7");
        for (int i = 0; i < 7; i++) begin
            move(1);
            repeat (4) @(negedge clk);
        end
        move(2);
        repeat (4) @(negedge clk);
        while (pos != 0) begin
            move(1);
            repeat (4) @(negedge clk);
        end
        total++;
        if (err_f !== 1'b1) begin
            bad++;
            $display("FAIL dirty_err: err=%b, want 1", err_f);
        end
    endtask

    task automatic check_restart(input string name);
        int start, first_k;
        start   = nv_f;
        first_k = -1;
        for (int k = 1; k <= WIN + 20; k++) begin
            @(negedge clk);
            if (nv_f != start) begin
                first_k = k;
                break;
            end
        end
        total++;
        if (first_k != WIN) begin
            bad++;
            $display("FAIL %s_latency: first speed_valid after %0d cycles, want %0d",
                     name, first_k, WIN);
        end
        exp_f.push_back({1'b0, 16'd0});
        exp_i.push_back({1'b0, 16'd0});
        check_window(name);
        total++;
        if (err_f !== 1'b0) begin
            bad++;
            $display("FAIL %s_err: err=%b, want 0", name, err_f);
        end
    endtask

    task automatic test_reset_mid_window();
        dirty_window();
        flush_small();
        #2;
        rst_n = 1'b0;
        #0.5;
        total++;
        if ({speed_f, valid_f, sat_f, err_f, speed_i, err_i} !== 36'd0) begin
            bad++;
            $display("FAIL rst_mid: fwd=%h inv=%h, want 0", {speed_f, valid_f, sat_f, err_f},
                     {speed_i, err_i});
        end
        #0.5;
        rst_n = 1'b1;
        check_restart("rst_restart");
    endtask

    task automatic test_clear_mid_window();
        dirty_window();
        // This step reaches the decoder on the clear cycle and must be dropped.
        move(1);
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        flush_small();
        @(negedge clk);
        total++;
        if ({speed_f, valid_f, sat_f, err_f, speed_i, err_i} !== 36'd0) begin
            bad++;
            $display("FAIL clr_mid: fwd=%h inv=%h, want 0", {speed_f, valid_f, sat_f, err_f},
                     {speed_i, err_i});
        end
        clear = 1'b0;
        check_restart("clr_restart");
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_forward();
        test_reverse_invert();
        test_window_boundary();
        test_illegal();
        test_reset_mid_window();
        test_clear_mid_window();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
